// File: rtl/mult8_seq_ctrl.sv
// Purpose : 8x8 unsigned multiply sequenced over one external 4x4 core.
// Latency : accept edge -> done after N+1 cycles (N = visited PP states, 4 unless SKIP_ZERO).
// Backpressure: start ignored while busy; abort cancels an in-flight op without done.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, a, b     operation request and operands (sampled when busy=0)
//   abort           cancel an in-flight operation
//   busy, done      PP-phase indicator, one-cycle completion pulse
//   product         last completed result, held until the next completion
//   mul_a, mul_b    nibbles driven to the external 4x4 core
//   mul_p           combinational core product mul_a*mul_b
module mult8_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PP0  = 3'd1;
    localparam logic [2:0] S_PP1  = 3'd2;
    localparam logic [2:0] S_PP2  = 3'd3;
    localparam logic [2:0] S_PP3  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  ra_q, ra_d;
    logic [7:0]  rb_q, rb_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] prod_q, prod_d;
    // Remaining PP states still to visit; bit i = PPi. Cleared as each is visited.
    logic [3:0]  rem_q, rem_d;

    logic [3:0]  accept_mask;
    logic [3:0]  cur_bit;
    logic [15:0] pp_term;

    // Which PP states an operation needs, decided once from the raw operands.
    function automatic logic [3:0] pp_mask(input logic [7:0] av, input logic [7:0] bv);
        logic [3:0] m;
        if (!SKIP_ZERO) begin
            m = 4'hF;
        end else begin
            m[0] = (|av[3:0]) & (|bv[3:0]);
            m[1] = (|av[7:4]) & (|bv[3:0]);
            m[2] = (|av[3:0]) & (|bv[7:4]);
            m[3] = (|av[7:4]) & (|bv[7:4]);
        end
        return m;
    endfunction

    // Lowest pending PP state, or DONE when nothing is left.
    function automatic logic [2:0] first_pp(input logic [3:0] m);
        logic [2:0] s;
        if (m[0])      s = S_PP0;
        else if (m[1]) s = S_PP1;
        else if (m[2]) s = S_PP2;
        else if (m[3]) s = S_PP3;
        else           s = S_DONE;
        return s;
    endfunction

    assign busy    = (state_q == S_PP0) || (state_q == S_PP1) ||
                     (state_q == S_PP2) || (state_q == S_PP3);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;

    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        rem_d       = rem_q;
        accept_mask = 4'h0;
        cur_bit     = 4'h0;
        pp_term     = 16'h0000;
        mul_a       = 4'h0;
        mul_b       = 4'h0;

        case (state_q)
            S_PP0: begin
                mul_a   = ra_q[3:0];
                mul_b   = rb_q[3:0];
                cur_bit = 4'b0001;
                pp_term = {8'h00, mul_p};
            end
            S_PP1: begin
                mul_a   = ra_q[7:4];
                mul_b   = rb_q[3:0];
                cur_bit = 4'b0010;
                pp_term = {4'h0, mul_p, 4'h0};
            end
            S_PP2: begin
                mul_a   = ra_q[3:0];
                mul_b   = rb_q[7:4];
                cur_bit = 4'b0100;
                pp_term = {4'h0, mul_p, 4'h0};
            end
            S_PP3: begin
                mul_a   = ra_q[7:4];
                mul_b   = rb_q[7:4];
                cur_bit = 4'b1000;
                pp_term = {mul_p, 8'h00};
            end
            default: ;
        endcase

        if (busy) begin
            if (abort) begin
                state_d = S_IDLE;
            end else begin
                acc_d   = acc_q + pp_term;
                rem_d   = rem_q & ~cur_bit;
                state_d = first_pp(rem_d);
                // Final partial product lands in product on the same edge as DONE entry.
                if (state_d == S_DONE) begin
                    prod_d = acc_d;
                end
            end
        end else begin
            // IDLE and DONE: start wins over abort here.
            if (start) begin
                accept_mask = pp_mask(a, b);
                ra_d        = a;
                rb_d        = b;
                acc_d       = 16'h0000;
                rem_d       = accept_mask;
                state_d     = first_pp(accept_mask);
                if (accept_mask == 4'h0) begin
                    prod_d = 16'h0000;
                end
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ra_q    <= 8'h00;
            rb_q    <= 8'h00;
            acc_q   <= 16'h0000;
            prod_q  <= 16'h0000;
            rem_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Purpose : self-checking bench for mult8_seq_ctrl, both SKIP_ZERO settings.
// Latency : inputs driven on falling edge, outputs sampled on falling edge.
// Backpressure: n/a (bench drives start only when the DUT can take it or to test ignore).
module tb_mult8_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT 0: SKIP_ZERO=0, DUT 1: SKIP_ZERO=1
    logic        start0 = 0, abort0 = 0, start1 = 0, abort1 = 0;
    logic [7:0]  a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic        busy0, done0, busy1, done1;
    logic [15:0] product0, product1;
    logic [3:0]  mula0, mulb0, mula1, mulb1;
    logic [7:0]  mulp0, mulp1;

    // External 4x4 combinational cores
    assign mulp0 = {4'h0, mula0} * {4'h0, mulb0};
    assign mulp1 = {4'h0, mula1} * {4'h0, mulb1};

    mult8_seq_ctrl #(.SKIP_ZERO(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .abort(abort0),
        .busy(busy0), .done(done0), .product(product0),
        .mul_a(mula0), .mul_b(mulb0), .mul_p(mulp0));

    mult8_seq_ctrl #(.SKIP_ZERO(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .abort(abort1),
        .busy(busy1), .done(done1), .product(product1),
        .mul_a(mula1), .mul_b(mulb1), .mul_p(mulp1));

    int checks = 0;
    int failures = 0;

    // Observation of one operation (index = cycle after accept edge)
    logic [3:0]  obs_ma [16];
    logic [3:0]  obs_mb [16];
    logic        obs_busy [16];
    logic [15:0] obs_prod;
    int          done_cyc;

    // Reference model results
    logic [3:0]  exp_ma [4];
    logic [3:0]  exp_mb [4];
    int          exp_n;
    logic [15:0] exp_prod;

    // Behavioural model: list of nibble pairs in PP order, filtered when skipping.
    task automatic model(input bit skip, input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] an, bn;
        exp_n    = 0;
        exp_prod = 16'(av) * 16'(bv);
        for (int k = 0; k < 4; k++) begin
            an = (k % 2 == 0) ? {4'h0, av[3:0]} : {4'h0, av[7:4]};
            bn = (k < 2)      ? {4'h0, bv[3:0]} : {4'h0, bv[7:4]};
            if (!skip || (an != 0 && bn != 0)) begin
                exp_ma[exp_n] = an[3:0];
                exp_mb[exp_n] = bn[3:0];
                exp_n++;
            end
        end
    endtask

    // Drives one start pulse (call just after a falling edge) and records the
    // trace until the done cycle, bounded at 12 cycles.
    task automatic launch(input bit sel, input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 16; i++) begin
            obs_ma[i] = 4'hx; obs_mb[i] = 4'hx; obs_busy[i] = 1'bx;
        end
        obs_prod = 16'hxxxx;
        done_cyc = -1;
        if (sel) begin start1 = 1; a1 = av; b1 = bv; end
        else     begin start0 = 1; a0 = av; b0 = bv; end
        for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start0 = 0; start1 = 0; abort0 = 0; abort1 = 0;
            end
            obs_ma[c]   = sel ? mula1 : mula0;
            obs_mb[c]   = sel ? mulb1 : mulb0;
            obs_busy[c] = sel ? busy1 : busy0;
            if (sel ? done1 : done0) begin
                done_cyc = c;
                obs_prod = sel ? product1 : product0;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks += 10;
        if (busy0 !== 1'b0)         begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
        if (done0 !== 1'b0)         begin failures++; $display("FAIL reset_done0 got=%b exp=0", done0); end
        if (product0 !== 16'h0000)  begin failures++; $display("FAIL reset_product0 got=%h exp=0000", product0); end
        if (mula0 !== 4'h0)         begin failures++; $display("FAIL reset_mula0 got=%h exp=0", mula0); end
        if (mulb0 !== 4'h0)         begin failures++; $display("FAIL reset_mulb0 got=%h exp=0", mulb0); end
        if (busy1 !== 1'b0)         begin failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        if (done1 !== 1'b0)         begin failures++; $display("FAIL reset_done1 got=%b exp=0", done1); end
        if (product1 !== 16'h0000)  begin failures++; $display("FAIL reset_product1 got=%h exp=0000", product1); end
        if (mula1 !== 4'h0)         begin failures++; $display("FAIL reset_mula1 got=%h exp=0", mula1); end
        if (mulb1 !== 4'h0)         begin failures++; $display("FAIL reset_mulb1 got=%h exp=0", mulb1); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        bit         sel_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] a_t   [4] = '{8'hFF, 8'h12, 8'h10, 8'h00};
        logic [7:0] b_t   [4] = '{8'hFF, 8'h34, 8'h03, 8'h5A};
        for (int t = 0; t < 4; t++) begin
            model(sel_t[t], a_t[t], b_t[t]);
            launch(sel_t[t], a_t[t], b_t[t]);
            checks += 2;
            if (done_cyc !== exp_n + 1) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", t, done_cyc, exp_n + 1); end
            if (obs_prod !== exp_prod)  begin failures++; $display("FAIL dir%0d_product got=%h exp=%h", t, obs_prod, exp_prod); end
            for (int c = 1; c <= exp_n; c++) begin
                checks += 3;
                if (obs_busy[c] !== 1'b1)        begin failures++; $display("FAIL dir%0d_busy c%0d got=%b exp=1", t, c, obs_busy[c]); end
                if (obs_ma[c] !== exp_ma[c - 1]) begin failures++; $display("FAIL dir%0d_mula c%0d got=%h exp=%h", t, c, obs_ma[c], exp_ma[c - 1]); end
                if (obs_mb[c] !== exp_mb[c - 1]) begin failures++; $display("FAIL dir%0d_mulb c%0d got=%h exp=%h", t, c, obs_mb[c], exp_mb[c - 1]); end
            end
            checks++;
            if (obs_busy[exp_n + 1] !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_done got=%b exp=0", t, obs_busy[exp_n + 1]); end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [7:0] av, bv;
        bit         sel;
        for (int t = 0; t < 40; t++) begin
            sel = t[0];
            for (int k = 0; k < 8; k += 4) begin
                av[k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                bv[k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            end
            model(sel, av, bv);
            launch(sel, av, bv);
            checks += 2;
            if (done_cyc !== exp_n + 1) begin failures++; $display("FAIL rnd%0d_latency a=%h b=%h got=%0d exp=%0d", t, av, bv, done_cyc, exp_n + 1); end
            if (obs_prod !== exp_prod)  begin failures++; $display("FAIL rnd%0d_product a=%h b=%h got=%h exp=%h", t, av, bv, obs_prod, exp_prod); end
            for (int c = 1; c <= exp_n; c++) begin
                checks += 2;
                if (obs_ma[c] !== exp_ma[c - 1] || obs_mb[c] !== exp_mb[c - 1]) begin
                    failures++;
                    $display("FAIL rnd%0d_core c%0d got=%h/%h exp=%h/%h", t, c, obs_ma[c], obs_mb[c], exp_ma[c - 1], exp_mb[c - 1]);
                end
                if (obs_busy[c] !== 1'b1) begin failures++; $display("FAIL rnd%0d_busy c%0d got=%b exp=1", t, c, obs_busy[c]); end
            end
            // One cycle later: done must have dropped and product must hold.
            @(negedge clk);
            checks += 2;
            if ((sel ? done1 : done0) !== 1'b0) begin failures++; $display("FAIL rnd%0d_done_width got=1 exp=0", t); end
            if ((sel ? product1 : product0) !== exp_prod) begin
                failures++; $display("FAIL rnd%0d_product_hold got=%h exp=%h", t, sel ? product1 : product0, exp_prod);
            end
        end
    endtask

    task automatic test_start_ignored;
        int dc = -1;
        logic [15:0] p = 16'hxxxx;
        start0 = 1; a0 = 8'h12; b0 = 8'h34;
        for (int c = 1; c <= 10 && dc < 0; c++) begin
            @(negedge clk);
            if (done0) begin dc = c; p = product0; end
            if (c == 1) start0 = 0;
            if (c == 2) begin start0 = 1; a0 = 8'h99; b0 = 8'h99; end
            if (c == 3) start0 = 0;
        end
        checks += 2;
        if (dc !== 5)        begin failures++; $display("FAIL ignore_latency got=%0d exp=5", dc); end
        if (p !== 16'h03A8)  begin failures++; $display("FAIL ignore_product got=%h exp=03a8", p); end
    endtask

    // Called while DUT 0 sits in its DONE cycle.
    task automatic test_back_to_back;
        model(1'b0, 8'h0F, 8'h0F);
        launch(1'b0, 8'h0F, 8'h0F);
        checks += 3;
        if (obs_busy[1] !== 1'b1)     begin failures++; $display("FAIL b2b_busy_c1 got=%b exp=1", obs_busy[1]); end
        if (done_cyc !== 5)           begin failures++; $display("FAIL b2b_latency got=%0d exp=5", done_cyc); end
        if (obs_prod !== 16'h00E1)    begin failures++; $display("FAIL b2b_product got=%h exp=00e1", obs_prod); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int pulses = 0;
        launch(1'b0, 8'h12, 8'h34);
        @(negedge clk);
        start0 = 1; a0 = 8'hFF; b0 = 8'hFF;
        @(negedge clk); start0 = 0;    // PP0
        @(negedge clk);                // PP1
        @(negedge clk);                // PP2
        checks++;
        if (busy0 !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", busy0); end
        abort0 = 1;
        @(negedge clk);
        abort0 = 0;
        checks++;
        if (busy0 !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy0); end
        for (int c = 0; c < 6; c++) begin
            if (done0) pulses++;
            @(negedge clk);
        end
        checks += 2;
        if (pulses !== 0)          begin failures++; $display("FAIL abort_done_pulses got=%0d exp=0", pulses); end
        if (product0 !== 16'h03A8) begin failures++; $display("FAIL abort_product got=%h exp=03a8", product0); end
        // abort together with start while idle: start wins
        abort0 = 1;
        launch(1'b0, 8'h21, 8'h03);
        checks += 2;
        if (done_cyc !== 5)        begin failures++; $display("FAIL abort_start_latency got=%0d exp=5", done_cyc); end
        if (obs_prod !== 16'h0063) begin failures++; $display("FAIL abort_start_product got=%h exp=0063", obs_prod); end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        start0 = 1; a0 = 8'hFF; b0 = 8'hFF;
        @(negedge clk); start0 = 0;    // PP0
        @(negedge clk);                // PP1
        #2 rst = 1;
        #1;
        checks += 5;
        if (busy0 !== 1'b0)        begin failures++; $display("FAIL arst_busy got=%b exp=0", busy0); end
        if (done0 !== 1'b0)        begin failures++; $display("FAIL arst_done got=%b exp=0", done0); end
        if (product0 !== 16'h0000) begin failures++; $display("FAIL arst_product got=%h exp=0000", product0); end
        if (mula0 !== 4'h0)        begin failures++; $display("FAIL arst_mula got=%h exp=0", mula0); end
        if (mulb0 !== 4'h0)        begin failures++; $display("FAIL arst_mulb got=%h exp=0", mulb0); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        launch(1'b0, 8'h12, 8'h34);
        checks += 2;
        if (done_cyc !== 5)        begin failures++; $display("FAIL arst_after_latency got=%0d exp=5", done_cyc); end
        if (obs_prod !== 16'h03A8) begin failures++; $display("FAIL arst_after_product got=%h exp=03a8", obs_prod); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_back_to_back;
        test_abort;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
